// File: rtl/sort_pkg.sv
// Shared definitions for the sort block and its read-back checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sort_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } verify_state_t;

endpackage

// File: rtl/sort_verify.sv
// Read-back checker: streams the sorted RAM and checks non-decreasing order,
// counting violations and summing the bytes.
// Latency: done rises n+1 cycles after the start edge (n = clamped len).
// Backpressure: none; start is ignored outside IDLE/DONE, RAM reads one word per cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, len        one-cycle run request and element count (clamped to depth)
//   mem_addr          RAM read address (registered)
//   mem_rdata         RAM q, one cycle after mem_addr
//   busy, done        high while issuing reads / level while results are held
//   pass, err_count, first_err_addr, checksum   results, final when done is high
module sort_verify
    import sort_pkg::*;
#(
    parameter int DATA_W = sort_pkg::DATA_W,
    parameter int ADDR_W = sort_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W+1:0] len,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [15:0]       checksum
);

    localparam logic [ADDR_W+1:0] LEN_MAX = (ADDR_W+2)'(2**ADDR_W);

    verify_state_t     state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] n_last_q, n_last_d;
    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] err_q, err_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic [15:0]       checksum_q, checksum_d;
    logic [ADDR_W:0]   n_clamped;

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        n_last_d   = n_last_q;
        vld_d      = 1'b0;
        idx_d      = idx_q;
        prev_d     = prev_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_d      = err_q;
        first_d    = first_q;
        checksum_d = checksum_q;
        n_clamped  = (len > LEN_MAX) ? LEN_MAX[ADDR_W:0] : len[ADDR_W:0];

        // Returning word: vld_q marks that mem_rdata holds element idx_q.
        if (vld_q) begin
            checksum_d = checksum_q + 16'(mem_rdata);
            if ((idx_q != '0) && (mem_rdata < prev_q)) begin
                err_d = err_q + ADDR_W'(1);
                if (err_q == '0) begin
                    first_d = idx_q;
                end
            end
            prev_d = mem_rdata;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    checksum_d = '0;
                    err_d      = '0;
                    first_d    = '0;
                    pass_d     = 1'b0;
                    done_d     = 1'b0;
                    mem_addr_d = '0;
                    n_last_d   = ADDR_W'(n_clamped - (ADDR_W+1)'(1));
                    // An empty run still passes through DRAIN so latency stays n+1.
                    if (n_clamped == '0) begin
                        state_d = DRAIN;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = READ;
                        busy_d  = 1'b1;
                    end
                end
            end
            READ: begin
                vld_d = 1'b1;
                idx_d = mem_addr_q;
                if (mem_addr_q == n_last_q) begin
                    state_d = DRAIN;
                    busy_d  = 1'b0;
                end else begin
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // The final word is folded in this cycle, so judge on err_d.
                state_d = DONE;
                done_d  = 1'b1;
                pass_d  = (err_d == '0);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            n_last_q   <= '0;
            vld_q      <= 1'b0;
            idx_q      <= '0;
            prev_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            first_q    <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            n_last_q   <= n_last_d;
            vld_q      <= vld_d;
            idx_q      <= idx_d;
            prev_q     <= prev_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            first_q    <= first_d;
            checksum_q <= checksum_d;
        end
    end

    assign mem_addr       = mem_addr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;
    assign checksum       = checksum_q;

endmodule
